// File: rtl/pow_seq_pkg.sv
// Shared types and constants for the power/multiple sequence generator.
package pow_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_POW = 1'b1;

endpackage

// File: rtl/pow_seq_gen_if.sv
// Control and output stream bundle of pow_seq_gen.
// The master side is the generator; the slave side is the controller/consumer.
interface pow_seq_gen_if #(
  parameter int WIDTH = 6,
  parameter int LEN_W = 4
) ();

  logic             start;
  logic [WIDTH-1:0] base;
  logic             mode;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] x;
  logic             x_valid;
  logic             x_ready;
  logic             x_last;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    input  start, base, mode, len, x_ready,
    output x, x_valid, x_last, busy, done, ovf
  );

  modport slave (
    output start, base, mode, len, x_ready,
    input  x, x_valid, x_last, busy, done, ovf
  );

endinterface

// File: rtl/pow_seq_step.sv
// Combinational next-term step: acc+base (multiples) or acc*base (powers),
// truncated to WIDTH bits, with a flag when the true result needs more bits.
module pow_seq_step
  import pow_seq_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] base,
  input  logic             mode,
  output logic [WIDTH-1:0] next_acc,
  output logic             step_ovf
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, acc} + {1'b0, base};
  assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base};

  // Select the step result and its overflow indication by mode
  always_comb begin
    next_acc = sum[WIDTH-1:0];
    step_ovf = sum[WIDTH];
    if (mode == MODE_POW) begin
      next_acc = prod[WIDTH-1:0];
      step_ovf = |prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/pow_seq_gen.sv
// Arithmetic sequence stimulus generator: emits len terms of base*k or
// base**k over a valid/ready stream, wrapping modulo 2**WIDTH with a
// sticky overflow flag.
// Optional build macro POW_SEQ_SAT_EN: once overflow is seen, every later
// term of the sequence is presented as all-ones.
module pow_seq_gen
  import pow_seq_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int LEN_W = 4
) (
  input logic           clk,
  input logic           rst,
  pow_seq_gen_if.master bus
);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] base_reg;
  logic             mode_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] k_reg;
  logic [WIDTH-1:0] x_reg;
  logic             x_valid_reg;
  logic             x_last_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] next_acc;
  logic             step_ovf;
  logic             ovf_next;
  logic [WIDTH-1:0] x_next;
  logic [LEN_W-1:0] k_inc;

  pow_seq_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .base     (base_reg),
    .mode     (mode_reg),
    .next_acc (next_acc),
    .step_ovf (step_ovf)
  );

  assign ovf_next = ovf_reg | step_ovf;
  assign k_inc    = k_reg + {{(LEN_W-1){1'b0}}, 1'b1};

`ifdef POW_SEQ_SAT_EN
  assign x_next = ovf_next ? {WIDTH{1'b1}} : next_acc;
`else
  assign x_next = next_acc;
`endif

  // Sequencer FSM with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      base_reg    <= '0;
      mode_reg    <= MODE_MUL;
      len_reg     <= '0;
      k_reg       <= '0;
      x_reg       <= '0;
      x_valid_reg <= 1'b0;
      x_last_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            base_reg <= bus.base;
            mode_reg <= bus.mode;
            len_reg  <= bus.len;
            acc_reg  <= bus.base;
            k_reg    <= {{(LEN_W-1){1'b0}}, 1'b1};
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b1;
            if (bus.len != '0) begin
              x_reg       <= bus.base;
              x_valid_reg <= 1'b1;
              x_last_reg  <= (bus.len == {{(LEN_W-1){1'b0}}, 1'b1});
              state_reg   <= EMIT;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        EMIT: begin
          if (bus.x_ready) begin
            if (k_reg == len_reg) begin
              x_valid_reg <= 1'b0;
              x_last_reg  <= 1'b0;
              state_reg   <= DONE;
            end else begin
              acc_reg    <= next_acc;
              k_reg      <= k_inc;
              ovf_reg    <= ovf_next;
              x_reg      <= x_next;
              x_last_reg <= (k_inc == len_reg);
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.x       = x_reg;
  assign bus.x_valid = x_valid_reg;
  assign bus.x_last  = x_last_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.ovf     = ovf_reg;

endmodule

// File: tb/tb_pow_seq_gen.sv
// Randomized self-checking bench for pow_seq_gen against a closed-form
// arithmetic model of the sequence terms and overflow flag.
module tb_pow_seq_gen;

  localparam int W    = 6;
  localparam int LW   = 4;
  localparam int MASK = (1 << W) - 1;
`ifdef POW_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pow_seq_gen_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  pow_seq_gen #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_x [16];
  int exp_o [16];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Term k is b*k or b**k; overflow once any true term exceeds MASK.
  task automatic build_model(input int b, input int m, input int l);
    longint t;
    int     w;
    exp_o[0] = 0;
    exp_x[0] = 0;
    for (int k = 1; k <= l; k++) begin
      if (m == 0) begin
        t = longint'(b * k);
        w = (b * k) & MASK;
      end else begin
        t = 1;
        w = 1;
        for (int i = 0; i < k; i++) begin
          t = t * b;
          if (t > (64'sd1 << 20)) t = 64'sd1 << 20;
          w = (w * b) & MASK;
        end
      end
      exp_o[k] = exp_o[k-1] | ((t > MASK) ? 1 : 0);
      exp_x[k] = (SAT && exp_o[k] != 0) ? MASK : w;
    end
  endtask

  // stall: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles on term 2
  task automatic run_seq(input int b, input int m, input int l, input int stall);
    int   j;
    int   cycles;
    int   stall_left;
    logic rdy;
    build_model(b, m, l);
    bus.start   = 1'b1;
    bus.base    = W'(b);
    bus.mode    = m[0];
    bus.len     = LW'(l);
    bus.x_ready = 1'($urandom_range(0, 1));
    cyc();
    bus.start = 1'b0;
    bus.base  = W'($urandom);
    bus.mode  = 1'($urandom);
    bus.len   = LW'($urandom);
    check("busy_start", int'(bus.busy), 1);
    check("ovf_cleared", int'(bus.ovf), 0);
    j          = 1;
    cycles     = 0;
    stall_left = (stall == 2) ? 3 : 0;
    while (j <= l && cycles < 200) begin
      check("x_valid", int'(bus.x_valid), 1);
      check("x",       int'(bus.x), exp_x[j]);
      check("x_last",  int'(bus.x_last), (j == l) ? 1 : 0);
      check("ovf",     int'(bus.ovf), exp_o[j]);
      check("busy",    int'(bus.busy), 1);
      check("done_lo", int'(bus.done), 0);
      if (stall == 0) rdy = 1'b1;
      else if (stall == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (j == 2 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else rdy = 1'b1;
      bus.x_ready = rdy;
      bus.start   = ($urandom_range(0, 3) == 0);
      if (rdy)
        $display("seq b=%0d m=%0d len=%0d term %0d x=%0d ovf=%0d",
                 b, m, l, j, bus.x, bus.ovf);
      cyc();
      cycles++;
      if (rdy) j++;
    end
    if (cycles >= 200) check("timeout", 0, 1);
    bus.start   = 1'b0;
    bus.x_ready = 1'($urandom_range(0, 1));
    check("done_state_valid", int'(bus.x_valid), 0);
    check("done_state_busy",  int'(bus.busy), 1);
    check("done_state_done",  int'(bus.done), 0);
    cyc();
    check("done_pulse", int'(bus.done), 1);
    check("busy_end",   int'(bus.busy), 0);
    check("ovf_end",    int'(bus.ovf), exp_o[l]);
    $display("seq b=%0d m=%0d len=%0d done", b, m, l);
    cyc();
    check("done_drop", int'(bus.done), 0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.base    = '0;
    bus.mode    = 1'b0;
    bus.len     = '0;
    bus.x_ready = 1'b0;
    rst         = 1'b1;
    cyc();
    cyc();
    check("rst_x",       int'(bus.x), 0);
    check("rst_x_valid", int'(bus.x_valid), 0);
    check("rst_x_last",  int'(bus.x_last), 0);
    check("rst_busy",    int'(bus.busy), 0);
    check("rst_done",    int'(bus.done), 0);
    check("rst_ovf",     int'(bus.ovf), 0);
    rst = 1'b0;
    cyc();

    run_seq(9, 1, 3, 0);
    run_seq(9, 0, 4, 0);
    run_seq(5, 0, 3, 2);
    run_seq(5, 0, 0, 0);
    run_seq(0, 1, 2, 0);
    run_seq(1, 1, 15, 1);
    run_seq(63, 0, 15, 1);

    // Reset while term 2 is presented
    bus.start   = 1'b1;
    bus.base    = W'(5);
    bus.mode    = 1'b0;
    bus.len     = LW'(3);
    bus.x_ready = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    check("mid_x_term2", int'(bus.x), 10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_x",       int'(bus.x), 0);
    check("mid_rst_x_valid", int'(bus.x_valid), 0);
    check("mid_rst_x_last",  int'(bus.x_last), 0);
    check("mid_rst_busy",    int'(bus.busy), 0);
    check("mid_rst_done",    int'(bus.done), 0);
    check("mid_rst_ovf",     int'(bus.ovf), 0);
    $display("reset during term 2 applied");
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_no_done", int'(bus.done), 0);
      check("post_rst_idle",    int'(bus.x_valid), 0);
    end
    run_seq(9, 1, 3, 1);

    for (int n = 0; n < 40; n++)
      run_seq($urandom_range(0, MASK), $urandom_range(0, 1), $urandom_range(0, 15), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
